// File: rtl/iot_pkg.sv
// Shared definitions for the IoT event serializer: update codes, word layout,
// transmitter states and small word/frame helpers.
package iot_pkg;

  localparam int WORD_W = 6;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_OFF  = 2'b01;
  localparam logic [1:0] CODE_ON   = 2'b10;
  localparam logic [1:0] CODE_RSVD = 2'b11;

  localparam int LIGHTS_LSB = 0;
  localparam int PLUGS_LSB  = 2;
  localparam int TEMP_LSB   = 4;

  localparam logic [1:0] FRAME_TAG = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Reserved codes still count as events so the hub sees them.
  function automatic logic code_active(input logic [1:0] code);
    case (code)
      CODE_OFF, CODE_ON, CODE_RSVD: return 1'b1;
      CODE_NONE:                    return 1'b0;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic word_has_event(input logic [WORD_W-1:0] word);
    return code_active(word[LIGHTS_LSB +: 2]) |
           code_active(word[PLUGS_LSB  +: 2]) |
           code_active(word[TEMP_LSB   +: 2]);
  endfunction

  function automatic logic [7:0] frame_byte(input logic [WORD_W-1:0] word);
    return {FRAME_TAG, word};
  endfunction

endpackage

// File: rtl/iot_event_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module iot_event_fifo
  import iot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_wr_en;
  logic              w_rd_en;

  assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/iot_event_serializer.sv
// Buffers non-zero device-update words and sends each one as a UART frame
// (start, 8 data bits LSB first, stop) carrying {FRAME_TAG, word}.
module iot_event_serializer
  import iot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_baud_done;
  logic              w_tx_nxt;
  logic [WORD_W-1:0] w_fifo_head;

  assign w_push      = word_has_event(data_in);
  assign w_baud_done = (r_baud == BAUD_LAST);

  iot_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (data_in),
    .o_data  (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // The next tx level is decided here so the line itself stays registered.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_baud_done) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_baud_done) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_baud_done) begin
          w_state_nxt = IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if ((w_state_nxt != r_state) || w_baud_done) r_baud <= '0;
      else                                         r_baud <= r_baud + 1'b1;
      if ((r_state == DATA) && w_baud_done) r_bit_idx <= r_bit_idx + 3'd1;
      r_tx <= w_tx_nxt;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Bit i of the frame byte sits in r_shift[0] while bit i is on the line.
  always_ff @(posedge clk) begin
    if (w_pop)                                      r_shift <= frame_byte(w_fifo_head);
    else if ((r_state == DATA) && w_baud_done)      r_shift <= r_shift >> 1;
  end

  assign tx       = r_tx;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE) | (fifo_count != '0);

endmodule
